// File: rtl/tx_sequencer_pkg.sv
// tx_sequencer shared definitions.
// State encoding and default timing constants.
package tx_sequencer_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_WAKE  = 3'd1;
   localparam logic [2:0] ST_LOAD  = 3'd2;
   localparam logic [2:0] ST_RUN   = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;
   localparam logic [2:0] ST_ERROR = 3'd5;

   typedef enum logic [2:0] {
      IDLE  = ST_IDLE,
      WAKE  = ST_WAKE,
      LOAD  = ST_LOAD,
      RUN   = ST_RUN,
      DONE  = ST_DONE,
      ERROR = ST_ERROR
   } state_e;

   localparam int DEF_WAKE_CYCLES    = 4;
   localparam int DEF_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/tx_sequencer_if.sv
// Start/done handshake and serializer control bundle.
// master = sequencer side, slave = SPI/serializer side.
interface tx_sequencer_if #(
   parameter int PAYLOAD_W = 32
);
   logic                 start_sync;
   logic                 mode_sync;
   logic [PAYLOAD_W-1:0] payload_in;
   logic                 ser_done_tick;
   logic                 err_clr;
   logic                 pwr_en;
   logic                 crc_load;
   logic                 ser_enable;
   logic                 ser_mode;
   logic [PAYLOAD_W-1:0] payload_out;
   logic                 done_level;
   logic                 busy;
   logic                 timeout_err;

   modport master (
      input  start_sync, mode_sync, payload_in,
      input  ser_done_tick, err_clr,
      output pwr_en, crc_load, ser_enable, ser_mode,
      output payload_out, done_level, busy, timeout_err
   );

   modport slave (
      output start_sync, mode_sync, payload_in,
      output ser_done_tick, err_clr,
      input  pwr_en, crc_load, ser_enable, ser_mode,
      input  payload_out, done_level, busy, timeout_err
   );
endinterface

// File: rtl/tx_sequencer_rise_detect.sv
// Registered rising-edge detector for a synchronized level.
// History resets high so a level already set at reset release is no edge.
module rise_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic rise
);
   logic prev_q;
   logic prev_d;

   always_comb prev_d = d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prev_q <= 1'b1;
      else        prev_q <= prev_d;
   end

   assign rise = d & ~prev_q;
endmodule

// File: rtl/tx_sequencer.sv
// Transmit-path sequencer: power-up, CRC load, serializer run, done.
// Moore FSM; every output is a flop decoded from the next state.
module tx_sequencer
   import tx_sequencer_pkg::*;
#(
   parameter int PAYLOAD_W      = 32,
   parameter int WAKE_CYCLES    = DEF_WAKE_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int CNT_W          = 11
) (
   input  logic            clk,
   input  logic            resetn,
   tx_sequencer_if.master  bus
);
   localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [PAYLOAD_W-1:0] payload_q, payload_d;
   logic                 ser_mode_q, ser_mode_d;
   logic                 pwr_en_q, pwr_en_d;
   logic                 crc_load_q, crc_load_d;
   logic                 ser_enable_q, ser_enable_d;
   logic                 done_level_q, done_level_d;
   logic                 busy_q, busy_d;
   logic                 timeout_err_q, timeout_err_d;
   logic                 start_rise;

   rise_detect u_start_rise (
      .clk   (clk),
      .rst_n (resetn),
      .d     (bus.start_sync),
      .rise  (start_rise)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      payload_d  = payload_q;
      ser_mode_d = ser_mode_q;
      case (state_q)
         IDLE: begin
            if (start_rise) begin
               state_d = WAKE;
               cnt_d   = '0;
            end
         end
         WAKE: begin
            if (cnt_q == WAKE_LAST) begin
               state_d = LOAD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         LOAD: begin
            state_d    = RUN;
            cnt_d      = '0;
            payload_d  = bus.payload_in;
            ser_mode_d = bus.mode_sync;
         end
         // done has priority over a coinciding timeout
         RUN: begin
            if (bus.ser_done_tick)     state_d = DONE;
            else if (cnt_q == TO_LAST) state_d = ERROR;
            else                       cnt_d = cnt_q + CNT_W'(1);
         end
         DONE: begin
            if (!bus.start_sync) state_d = IDLE;
         end
         ERROR: begin
            if (bus.err_clr && !bus.start_sync) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      pwr_en_d      = (state_d == WAKE) || (state_d == LOAD) ||
                      (state_d == RUN);
      crc_load_d    = (state_d == LOAD);
      ser_enable_d  = (state_d == RUN);
      done_level_d  = (state_d == DONE) || (state_d == ERROR);
      busy_d        = (state_d != IDLE);
      timeout_err_d = (state_d == ERROR);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         payload_q     <= '0;
         ser_mode_q    <= 1'b0;
         pwr_en_q      <= 1'b0;
         crc_load_q    <= 1'b0;
         ser_enable_q  <= 1'b0;
         done_level_q  <= 1'b0;
         busy_q        <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         payload_q     <= payload_d;
         ser_mode_q    <= ser_mode_d;
         pwr_en_q      <= pwr_en_d;
         crc_load_q    <= crc_load_d;
         ser_enable_q  <= ser_enable_d;
         done_level_q  <= done_level_d;
         busy_q        <= busy_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign bus.pwr_en      = pwr_en_q;
   assign bus.crc_load    = crc_load_q;
   assign bus.ser_enable  = ser_enable_q;
   assign bus.ser_mode    = ser_mode_q;
   assign bus.payload_out = payload_q;
   assign bus.done_level  = done_level_q;
   assign bus.busy        = busy_q;
   assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_tx_sequencer.sv
// Directed bench: dut A has the long timeout, dut B a 16-cycle timeout.
// Inputs change and outputs are checked 1 time unit after each posedge.
module tb_tx_sequencer;
   logic clk;
   logic resetn;
   int   errors;
   int   checks;
   int   crc_cnt_a;

   tx_sequencer_if #(.PAYLOAD_W(32)) bus_a ();
   tx_sequencer_if #(.PAYLOAD_W(32)) bus_b ();

   tx_sequencer #(
      .PAYLOAD_W(32), .WAKE_CYCLES(4),
      .TIMEOUT_CYCLES(1024), .CNT_W(11)
   ) dut_a (
      .clk(clk), .resetn(resetn), .bus(bus_a)
   );

   tx_sequencer #(
      .PAYLOAD_W(32), .WAKE_CYCLES(4),
      .TIMEOUT_CYCLES(16), .CNT_W(11)
   ) dut_b (
      .clk(clk), .resetn(resetn), .bus(bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (bus_a.crc_load === 1'b1) crc_cnt_a++;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      errors    = 0;
      checks    = 0;
      crc_cnt_a = 0;
      resetn    = 1'b0;
      bus_a.start_sync = 0; bus_a.mode_sync = 0; bus_a.payload_in = '0;
      bus_a.ser_done_tick = 0; bus_a.err_clr = 0;
      bus_b.start_sync = 0; bus_b.mode_sync = 0; bus_b.payload_in = '0;
      bus_b.ser_done_tick = 0; bus_b.err_clr = 0;
      tick(3);
      check("rst_busy", bus_a.busy, 0);
      check("rst_pwr", bus_a.pwr_en, 0);
      check("rst_payload", bus_a.payload_out, 0);
      resetn = 1'b1;
      tick(2);

      // normal transfer
      bus_a.start_sync = 1; bus_a.mode_sync = 1;
      bus_a.payload_in = 32'hA5A5_1234;
      tick();
      check("wake_pwr", bus_a.pwr_en, 1);
      check("wake_busy", bus_a.busy, 1);
      check("wake_crc0", bus_a.crc_load, 0);
      bus_a.ser_done_tick = 1;
      tick();
      bus_a.ser_done_tick = 0;
      check("wake_tick_ign", bus_a.done_level, 0);
      tick(2);
      check("crc_early", bus_a.crc_load, 0);
      tick();
      check("crc_at5", bus_a.crc_load, 1);
      check("load_ser0", bus_a.ser_enable, 0);
      tick();
      check("ser_at6", bus_a.ser_enable, 1);
      check("crc_drop", bus_a.crc_load, 0);
      check("payload", bus_a.payload_out, 32'hA5A5_1234);
      check("mode", bus_a.ser_mode, 1);
      tick(39);
      check("run_hold", bus_a.ser_enable, 1);
      bus_a.ser_done_tick = 1;
      tick();
      bus_a.ser_done_tick = 0;
      check("done_up", bus_a.done_level, 1);
      check("done_pwr", bus_a.pwr_en, 0);
      check("done_ser", bus_a.ser_enable, 0);
      tick(2);
      check("done_hold", bus_a.done_level, 1);
      bus_a.start_sync = 0;
      tick();
      check("done_down", bus_a.done_level, 0);
      check("busy_down", bus_a.busy, 0);

      // spurious done in IDLE
      bus_a.ser_done_tick = 1;
      tick();
      bus_a.ser_done_tick = 0;
      tick();
      check("idle_tick_ign", bus_a.done_level, 0);
      check("idle_tick_busy", bus_a.busy, 0);

      // second edge during RUN, then async reset mid-RUN
      bus_a.start_sync = 1; bus_a.mode_sync = 0;
      bus_a.payload_in = 32'h0000_00FF;
      tick(6);
      check("run2_ser", bus_a.ser_enable, 1);
      bus_a.start_sync = 0;
      tick();
      bus_a.start_sync = 1;
      tick(3);
      check("one_crc", crc_cnt_a, 2);
      check("run2_still", bus_a.ser_enable, 1);
      #2;
      resetn = 1'b0;
      #1;
      check("arst_ser", bus_a.ser_enable, 0);
      check("arst_pwr", bus_a.pwr_en, 0);
      check("arst_busy", bus_a.busy, 0);
      check("arst_payload", bus_a.payload_out, 0);
      check("arst_done", bus_a.done_level, 0);
      tick();
      resetn = 1'b1;
      tick(3);
      check("held_start_busy", bus_a.busy, 0);
      check("held_start_pwr", bus_a.pwr_en, 0);

      // restart, start dropped early in WAKE
      bus_a.start_sync = 0;
      tick();
      bus_a.start_sync = 1; bus_a.mode_sync = 0;
      bus_a.payload_in = 32'h1357_9BDF;
      tick();
      check("re_pwr", bus_a.pwr_en, 1);
      bus_a.start_sync = 0;
      tick(4);
      check("early_crc", bus_a.crc_load, 1);
      tick();
      check("early_ser", bus_a.ser_enable, 1);
      check("early_payload", bus_a.payload_out, 32'h1357_9BDF);
      check("early_mode", bus_a.ser_mode, 0);
      bus_a.ser_done_tick = 1;
      tick();
      bus_a.ser_done_tick = 0;
      check("early_done", bus_a.done_level, 1);
      tick();
      check("early_done_drop", bus_a.done_level, 0);
      check("early_idle", bus_a.busy, 0);
      check("crc_total", crc_cnt_a, 3);

      // timeout on dut B
      bus_b.start_sync = 1; bus_b.payload_in = 32'hDEAD_BEEF;
      tick(6);
      check("b_run", bus_b.ser_enable, 1);
      tick(15);
      check("b_run_last", bus_b.ser_enable, 1);
      check("b_no_err", bus_b.timeout_err, 0);
      tick();
      check("to_err", bus_b.timeout_err, 1);
      check("to_done", bus_b.done_level, 1);
      check("to_pwr", bus_b.pwr_en, 0);
      check("to_busy", bus_b.busy, 1);
      bus_b.err_clr = 1;
      tick();
      check("clr_start_hi", bus_b.timeout_err, 1);
      bus_b.start_sync = 0;
      tick();
      bus_b.err_clr = 0;
      check("clr_err", bus_b.timeout_err, 0);
      check("clr_done", bus_b.done_level, 0);
      check("clr_busy", bus_b.busy, 0);

      // done coinciding with the final timeout cycle
      bus_b.start_sync = 1;
      tick(6);
      tick(15);
      bus_b.ser_done_tick = 1;
      tick();
      bus_b.ser_done_tick = 0;
      check("sim_done", bus_b.done_level, 1);
      check("sim_no_err", bus_b.timeout_err, 0);
      bus_b.start_sync = 0;
      tick();
      check("sim_idle", bus_b.busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/tx_sequencer.md
Name: tx_sequencer

Overview:
- Sys_clk-domain controller that sequences the CRC/serializer transmit path.
- Accepts the synchronized start/mode levels and the SPI-register payload, then runs the path in order: power-up (clock-enable), CRC load, serializer enable, wait for done.
- Returns a held done level, suitable for a bit synchronizer, to the SPI domain (4-phase start/done handshake).
- Gates the serializer clock-enable whenever idle (low-power), and flags a timeout if the serializer never completes.

Parameters:
- PAYLOAD_W, 32, payload width
- WAKE_CYCLES, 4, cycles between power-enable and CRC load (min 1)
- TIMEOUT_CYCLES, 1024, max RUN cycles before error (min 2)
- CNT_W, 11, counter width; must hold max(WAKE_CYCLES, TIMEOUT_CYCLES)

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- start_sync  in  1  synchronized start level from the SPI domain
- mode_sync  in  1  synchronized mode level
- payload_in  in  PAYLOAD_W  payload from the register file; quasi-static while start is high
- ser_done_tick  in  1  one-cycle done pulse from the serializer
- err_clr  in  1  clears the ERROR state
- pwr_en  out  1  clock-enable/power request for the CRC/serializer
- crc_load  out  1  one-cycle CRC load strobe
- ser_enable  out  1  serializer enable, held during RUN
- ser_mode  out  1  mode latched at LOAD
- payload_out  out  PAYLOAD_W  payload latched at LOAD
- done_level  out  1  held done flag, returned through a bit synchronizer
- busy  out  1  high in any state except IDLE
- timeout_err  out  1  sticky error flag

Behaviour:
- Reset: all outputs 0, payload_out 0, counter 0, state IDLE. Reset asserted at any point aborts immediately, with no done and no error.
- All outputs are registered; the state machine is Moore.
- IDLE:
  - Wait for a rising edge of start_sync (registered previous value 0, current 1).
  - A level that is already high at reset release is NOT a start.
  - On the edge: go to WAKE, pwr_en=1, counter cleared.
- WAKE:
  - pwr_en=1; counter increments.
  - When counter == WAKE_CYCLES-1, go to LOAD.
- LOAD (exactly 1 cycle):
  - crc_load=1.
  - payload_out <= payload_in and ser_mode <= mode_sync, both captured this cycle.
  - Next state RUN; counter cleared.
- RUN:
  - ser_enable=1, pwr_en=1; counter increments each cycle.
  - ser_done_tick=1 → DONE. Done wins if it coincides with a timeout.
  - counter == TIMEOUT_CYCLES-1 with no done → ERROR.
  - A ser_done_tick arriving outside RUN is ignored.
- DONE:
  - done_level=1, pwr_en=0, ser_enable=0.
  - Hold until start_sync==0, then go to IDLE and drop done_level.
  - This gives the 4-phase handshake: start↑, done↑, start↓, done↓.
- ERROR:
  - timeout_err=1, done_level=1 (releases the SPI side), pwr_en=0.
  - Leave to IDLE only when err_clr=1 AND start_sync==0.
  - err_clr while start is still high is ignored.
- start_sync falling during WAKE/LOAD/RUN does not abort; the transfer completes, and DONE exits immediately on the next cycle because start is already low.
- A new rising edge is accepted only from IDLE. Edges that occur outside IDLE are discarded, because the edge detector is only evaluated in IDLE.
- payload_out and ser_mode stay stable from LOAD until the next LOAD.
- Latency: start edge → crc_load is WAKE_CYCLES+1 cycles; start edge → ser_enable is WAKE_CYCLES+2 cycles.

Decomposition:
- Shared package: state encoding (IDLE, WAKE, LOAD, RUN, DONE, ERROR as 3-bit localparams), default WAKE_CYCLES/TIMEOUT_CYCLES constants.
- One sub-module: rise_detect (1-bit registered edge detector with async active-low reset), reusable for other synchronized request lines.
- The counter and state machine stay inline.

Test Plan:
- Normal transfer, WAKE_CYCLES=4:
  - Stimulus: start_sync↑ with payload 0xA5A5_1234, mode 1; ser_done_tick pulsed 40 cycles after ser_enable↑; start_sync dropped after done_level↑.
  - Required: pwr_en↑ 1 cycle after the edge; crc_load pulse at edge+5; payload_out=0xA5A5_1234 and ser_mode=1; done_level↑ 1 cycle after the tick; done_level↓ 1 cycle after start↓; busy falls with it.
- Timeout, TIMEOUT_CYCLES=16:
  - Stimulus: no done tick.
  - Required: ERROR after 16 RUN cycles; timeout_err=1, done_level=1, pwr_en=0.
  - Stimulus: err_clr with start high. Required: stays in ERROR.
  - Stimulus: start low + err_clr. Required: IDLE with all flags 0.
- Simultaneous: ser_done_tick in the final timeout cycle → DONE, timeout_err stays 0.
- Reset mid-RUN: resetn↓ asynchronously mid-RUN → all outputs 0 within the same cycle (no clock edge needed); start_sync held high through reset release → no new transfer until start↓ then ↑.
- Spurious inputs:
  - ser_done_tick pulsed in IDLE and in WAKE → ignored, no done_level.
  - Second start edge during RUN → ignored; exactly one crc_load per accepted transfer.
- Early start drop:
  - Stimulus: start_sync↓ during WAKE.
  - Required: the transfer completes; done_level pulses for 1 cycle in DONE, then IDLE.
